// File: rtl/shift_left_seq.sv
// Sequential left shifter: shifts the operand by one bit per cycle, then
// registers the result with a done pulse and a sticky overflow flag.
module shift_left_seq #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [CNTW-1:0]  b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx, c_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic             ovf_acc, ovf_acc_nx, ovf_nx, busy_nx, done_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      c       <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      cnt     <= cnt_nx;
      ovf_acc <= ovf_acc_nx;
      c       <= c_nx;
      ovf     <= ovf_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    cnt_nx     = cnt;
    ovf_acc_nx = ovf_acc;
    c_nx       = c;
    ovf_nx     = ovf;
    busy_nx    = busy;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nx     = a;
          cnt_nx     = b;
          ovf_acc_nx = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          acc_nx     = {acc[WIDTH-2:0], 1'b0};
          ovf_acc_nx = ovf_acc | acc[WIDTH-1];
          cnt_nx     = cnt - 1'b1;
        end else begin
          // Result and flag only move here, so they hold across the whole shift.
          c_nx     = acc;
          ovf_nx   = ovf_acc;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed cases plus randomized
// operations compared against an arithmetic model of a << b.
module tb_shift_left_seq;

  localparam int unsigned WIDTH = 20;
  localparam int unsigned CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [CNTW-1:0]  b;
  logic [WIDTH-1:0] c;
  logic             busy, done, ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_c;
  logic             exp_ovf;

  shift_left_seq #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .c(c), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full-precision shift: low WIDTH bits are the result, anything above is overflow.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [CNTW-1:0] bv);
    logic [63:0] full;
    full = 64'(av) << bv;
    return {|(full >> WIDTH), full[WIDTH-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [WIDTH-1:0] av, input logic [CNTW-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_done", 64'(done), 64'd0);
  endtask

  // Runs the remaining b+1 edges; disturb=1 drives start/a/b hard, else random junk.
  task automatic finish(input logic [WIDTH-1:0] av, input logic [CNTW-1:0] bv, input bit disturb);
    logic [WIDTH:0] r;
    r = model(av, bv);
    for (int unsigned i = 0; i < 32'(bv); i++) begin
      if (disturb) begin
        start = 1'b1; a = '1; b = 4'd1;
      end else begin
        start = 1'($urandom); a = WIDTH'($urandom); b = CNTW'($urandom);
      end
      step();
      chk("shift_busy", 64'(busy), 64'd1);
      chk("shift_done", 64'(done), 64'd0);
      chk("shift_c_hold", 64'(c), 64'(exp_c));
      chk("shift_ovf_hold", 64'(ovf), 64'(exp_ovf));
    end
    start = 1'b0;
    step();
    exp_c   = r[WIDTH-1:0];
    exp_ovf = r[WIDTH];
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_c", 64'(c), 64'(exp_c));
    chk("end_ovf", 64'(ovf), 64'(exp_ovf));
  endtask

  task automatic idle_step();
    start = 1'b0;
    step();
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_c", 64'(c), 64'(exp_c));
    chk("idle_ovf", 64'(ovf), 64'(exp_ovf));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [CNTW-1:0] bv);
    launch(av, bv);
    finish(av, bv, 1'b0);
    idle_step();
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [CNTW-1:0]  rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    exp_c = '0; exp_ovf = 1'b0;
    #12;
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    step();
    rst_n = 1'b1;
    idle_step();

    run_op(20'h00001, 4'd4);
    run_op(20'h80001, 4'd1);
    run_op(20'h00003, 4'd2);
    run_op(20'hABCDE, 4'd0);
    chk("b0_c", 64'(c), 64'hABCDE);

    // Start/a/b forced during busy must not disturb the running op.
    launch(20'h00001, 4'd15);
    finish(20'h00001, 4'd15, 1'b1);
    chk("ign_c", 64'(c), 64'h08000);
    idle_step();

    // Reset mid-operation aborts and suppresses the done pulse.
    launch(20'h00F00, 4'd8);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_c", 64'(c), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    exp_c = '0; exp_ovf = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) idle_step();

    // Back-to-back: second start held high in the done cycle.
    launch(20'h00005, 4'd3);
    finish(20'h00005, 4'd3, 1'b0);
    launch(20'hC0000, 4'd2);
    finish(20'hC0000, 4'd2, 1'b0);
    idle_step();

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = CNTW'($urandom_range(0, 15));
      launch(ra, rb);
      finish(ra, rb, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_step();
    end
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
